// File: rtl/vc_buf_pkg.sv
// Shared helpers for the multi-VC flit buffer: width arithmetic and the
// layout of the flattened per-VC count bus.
package vc_buf_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_CNT_WIDTH  = DEF_ADDR_WIDTH + 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  // A count must hold 0..DEPTH inclusive, hence one bit more than a pointer.
  function automatic int cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int cnt_lsb(input int vc, input int addr_w);
    return vc * (addr_w + 1);
  endfunction

endpackage

// File: rtl/vc_buf_ram.sv
// Simple dual-port RAM with a registered, read-first output port.
// Only the output register is reset; the array contents are left alone.
module vc_buf_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int WORDS = 1 << AW;

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The combinational read sees the pre-edge array, so a colliding write
  // returns the old word.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vc_flit_buffer.sv
// Multi-virtual-channel flit buffer: one shared RAM split into VC_NUM
// circular queues with per-VC counts, status and sticky error flags.
module vc_flit_buffer
  import vc_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int VC_NUM     = 4,
  parameter int VC_WIDTH   = 2,
  parameter int AF_MARGIN  = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [VC_WIDTH-1:0]               wr_vc,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              rd_en,
  input  logic [VC_WIDTH-1:0]               rd_vc,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic                              rd_valid,
  output logic [VC_WIDTH-1:0]               rd_vc_q,
  output logic [VC_NUM-1:0]                 vc_not_empty,
  output logic [VC_NUM-1:0]                 vc_full,
  output logic [VC_NUM-1:0]                 vc_almost_full,
  output logic [VC_NUM*(ADDR_WIDTH+1)-1:0]  vc_count,
  input  logic                              err_clr,
  output logic                              overflow_err,
  output logic                              underflow_err
);

  localparam int CNT_W = cnt_width(ADDR_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int RAM_AW = ADDR_WIDTH + VC_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(DEPTH - AF_MARGIN);

  logic [ADDR_WIDTH-1:0] wr_ptr_q [VC_NUM];
  logic [ADDR_WIDTH-1:0] wr_ptr_d [VC_NUM];
  logic [ADDR_WIDTH-1:0] rd_ptr_q [VC_NUM];
  logic [ADDR_WIDTH-1:0] rd_ptr_d [VC_NUM];
  logic [CNT_W-1:0]      cnt_q    [VC_NUM];
  logic [CNT_W-1:0]      cnt_d    [VC_NUM];

  logic                  rd_valid_q, rd_valid_d;
  logic [VC_WIDTH-1:0]   rd_vc_qq, rd_vc_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic [RAM_AW-1:0]     ram_waddr;
  logic [RAM_AW-1:0]     ram_raddr;

  // Status is a pure function of the count registers.
  always_comb begin
    vc_not_empty   = '0;
    vc_full        = '0;
    vc_almost_full = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      vc_not_empty[v]   = (cnt_q[v] != '0);
      vc_full[v]        = (cnt_q[v] == DEPTH_C);
      vc_almost_full[v] = (cnt_q[v] >= AF_C);
    end
  end

  for (genvar g = 0; g < VC_NUM; g++) begin : g_cnt_out
    assign vc_count[cnt_lsb(g, ADDR_WIDTH) +: CNT_W] = cnt_q[g];
  end

  // A full VC can still take a write when the same edge frees a slot in it.
  always_comb begin
    rd_acc = rd_en & vc_not_empty[rd_vc];
    wr_acc = wr_en & (~vc_full[wr_vc] | (rd_acc & (rd_vc == wr_vc)));
  end

  assign ram_waddr = {wr_vc, wr_ptr_q[wr_vc]};
  assign ram_raddr = {rd_vc, rd_ptr_q[rd_vc]};

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      wr_ptr_d[v] = wr_ptr_q[v];
      rd_ptr_d[v] = rd_ptr_q[v];
      cnt_d[v]    = cnt_q[v];
    end
    for (int v = 0; v < VC_NUM; v++) begin
      logic inc;
      logic dec;
      inc = wr_acc & (wr_vc == VC_WIDTH'(v));
      dec = rd_acc & (rd_vc == VC_WIDTH'(v));
      if (inc) wr_ptr_d[v] = wr_ptr_q[v] + 1'b1;
      if (dec) rd_ptr_d[v] = rd_ptr_q[v] + 1'b1;
      if (inc && !dec)      cnt_d[v] = cnt_q[v] + 1'b1;
      else if (dec && !inc) cnt_d[v] = cnt_q[v] - 1'b1;
    end
  end

  // Clear wins over a same-cycle error so software never loses a clear.
  always_comb begin
    rd_valid_d = rd_acc;
    rd_vc_d    = rd_acc ? rd_vc : rd_vc_qq;
    ovf_d      = ovf_q | (wr_en & ~wr_acc);
    unf_d      = unf_q | (rd_en & ~rd_acc);
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
      rd_valid_q <= 1'b0;
      rd_vc_qq   <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        cnt_q[v]    <= cnt_d[v];
      end
      rd_valid_q <= rd_valid_d;
      rd_vc_qq   <= rd_vc_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  vc_buf_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (ram_waddr),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (ram_raddr),
    .rdata (rd_data)
  );

  assign rd_valid      = rd_valid_q;
  assign rd_vc_q       = rd_vc_qq;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: doc/vc_flit_buffer.md
Name: vc_flit_buffer

Overview:
Multi-virtual-channel flit buffer. It is the next generation of the single-queue flit FIFO used at router input ports. One shared simple-dual-port RAM is statically partitioned into VC_NUM independent circular queues, each of depth 2**ADDR_WIDTH. Compared with the single-queue FIFO, it adds:
- full-depth counting;
- per-VC full and almost-full status for credit/backpressure;
- sticky overflow/underflow error flags;
- a registered read with an explicit valid qualifier.

Parameters:
DATA_WIDTH, 32, flit width in bits
ADDR_WIDTH, 4, log2 of per-VC depth; DEPTH = 2**ADDR_WIDTH
VC_NUM, 4, number of virtual channels (power of two, >= 2)
VC_WIDTH, 2, log2(VC_NUM); must be consistent with VC_NUM
AF_MARGIN, 2, almost_full asserts when count >= DEPTH - AF_MARGIN

Ports:
clk  input  1  clock; all logic on its rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
wr_en  input  1  write request
wr_vc  input  VC_WIDTH  target VC of write
wr_data  input  DATA_WIDTH  flit to store
rd_en  input  1  read request
rd_vc  input  VC_WIDTH  source VC of read
rd_data  output  DATA_WIDTH  read flit, valid when rd_valid
rd_valid  output  1  rd_data/rd_vc_q carry an accepted read
rd_vc_q  output  VC_WIDTH  VC of the flit on rd_data
vc_not_empty  output  VC_NUM  bit v = count[v] != 0
vc_full  output  VC_NUM  bit v = count[v] == DEPTH
vc_almost_full  output  VC_NUM  bit v = count[v] >= DEPTH-AF_MARGIN
vc_count  output  VC_NUM*(ADDR_WIDTH+1)  flattened counts, VC v at [v*(ADDR_WIDTH+1) +: ADDR_WIDTH+1]
err_clr  input  1  clears sticky error flags
overflow_err  output  1  sticky: a write to a full VC was dropped
underflow_err  output  1  sticky: a read of an empty VC was rejected

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - all wr_ptr/rd_ptr/count cleared;
  - rd_valid=0, rd_data=0, rd_vc_q=0;
  - errors=0; vc_not_empty=0, vc_full=0, vc_almost_full=0 (AF_MARGIN<DEPTH).
  - RAM contents are not cleared.
  - Reset mid-traffic discards all queued flits. A read accepted in the cycle of reset produces no rd_valid.
- Per-VC state:
  - wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap modulo DEPTH.
  - count is ADDR_WIDTH+1 bits, range 0..DEPTH.
- RAM address is {vc, ptr}.
- Write acceptance: wr_acc = wr_en & (~vc_full[wr_vc] | (rd_acc & rd_vc==wr_vc)).
  - An accepted write stores the flit and increments wr_ptr.
  - A write to a full VC without a same-VC accepted read is dropped and sets overflow_err. Pointers and count are unchanged.
- Read acceptance: rd_acc = rd_en & vc_not_empty[rd_vc], evaluated on pre-edge state.
  - There is no write-to-read bypass.
  - A read of an empty VC sets underflow_err, is ignored, and yields no rd_valid, even if a write to the same VC occurs that cycle.
- Read latency is 1 cycle. On the edge that accepts a read, the RAM captures the flit into its output register. The next cycle presents rd_valid=1, rd_data and rd_vc_q. rd_valid deasserts in any cycle following no accepted read. rd_data holds its last value when rd_valid=0.
- Count update per VC: +1 on write-only, -1 on read-only, unchanged when both hit the same VC or neither does. Different VCs update independently in the same cycle.
- The RAM is read-first. A simultaneous read and write of a full VC address the same slot and must return the old flit.
- Status outputs are combinational from the count registers and reflect the post-edge state.
- err_clr has priority over a new error in the same cycle: the flags clear, and that cycle's error is lost.
- The following cannot occur by construction: out-of-range VC indices, pointer overrun, and count outside 0..DEPTH.

Decomposition:
- Package vc_buf_pkg holds:
  - clog2 helper;
  - count-width constant (ADDR_WIDTH+1);
  - the slice-index function for vc_count.
- Sub-module vc_buf_ram:
  - simple dual-port, one write port and one read port;
  - registered read-first output, synchronous active-low reset of the output register only;
  - parameters DATA_WIDTH and ADDR_WIDTH+VC_WIDTH.
- The top holds pointer/count arrays and acceptance logic.

Test Plan:
- Reset, then write 0xA0..0xA3 to VC1 and read VC1 four times -> rd_valid pulses 1 cycle after each rd_en with 0xA0..0xA3 in order, rd_vc_q=1; vc_count[1] returns to 0.
- Write 16 flits to VC2 (DEPTH=16) -> vc_almost_full[2] at count 14, vc_full[2] at 16. 17th write dropped, overflow_err=1, count stays 16. Then err_clr -> overflow_err=0.
- VC3 full: same-cycle write 0xBB and read VC3 -> read returns oldest flit (not 0xBB), write accepted, count stays 16, no overflow.
- VC0 empty: same-cycle write 0x55 and read VC0 -> no rd_valid, underflow_err=1, count[0]=1. Next read returns 0x55.
- Interleave writes to VC0 and reads from VC1 over 40 cycles with wrap-around (>DEPTH total per VC) -> per-VC order preserved, no cross-VC corruption, counts match a reference model.
- Assert rst_n=0 for one cycle mid-stream with an accepted read -> next cycle rd_valid=0, all counts 0, errors 0; the first flit written afterwards is read back correctly.
